// File: rtl/video_pixel_gen.sv
// video_pixel_gen: character-cell pixel generator behind video_crtc.
// Fetches code and glyph row once per character time and shifts the row out at
// the pixel rate. Pixels and syncs are both delayed by one character time.
module video_pixel_gen (
   input  logic        sys_clock_i,
   input  logic        reset_i,
   input  logic        clk1n_en_i,
   input  logic        pixel_en_i,
   input  logic        de_i,
   input  logic [13:0] ma_i,
   input  logic [4:0]  ra_i,
   input  logic        h_sync_i,
   input  logic        v_sync_i,
   input  logic        gfx_i,
   output logic [10:0] vram_addr_o,
   output logic        vram_req_o,
   input  logic        vram_ack_i,
   input  logic [7:0]  vram_data_i,
   output logic [10:0] rom_addr_o,
   output logic        rom_req_o,
   input  logic        rom_ack_i,
   input  logic [7:0]  rom_data_i,
   output logic        video_o,
   output logic        h_sync_o,
   output logic        v_sync_o,
   output logic        underrun_o
);

   typedef enum logic [1:0] {IDLE, VRAM, ROM, READY} state_t;

   state_t     state;
   logic       restart;
   logic       de_q;
   logic [4:0] ra_q;
   logic       gfx_q;
   logic [7:0] pending;
   logic       pending_inv;
   logic [7:0] shreg;
   logic       inv_q;
   logic       h_pipe;
   logic       v_pipe;
   logic       busy;
   logic       unused_ma;

   // Upper address bits select nothing inside the 2K video RAM.
   assign unused_ma = ^ma_i[13:11];

   // A fetch is still outstanding while waiting on either memory.
   always_comb begin
      busy = (state == VRAM) || (state == ROM);
   end

   // Fetch FSM: code from video RAM, then glyph row from character ROM.
   always_ff @(posedge sys_clock_i) begin
      if (reset_i) begin
         state       <= IDLE;
         restart     <= 1'b0;
         de_q        <= 1'b0;
         ra_q        <= '0;
         gfx_q       <= 1'b0;
         pending     <= '0;
         pending_inv <= 1'b0;
         vram_req_o  <= 1'b0;
         rom_req_o   <= 1'b0;
         vram_addr_o <= '0;
         rom_addr_o  <= '0;
         underrun_o  <= 1'b0;
      end else begin
         underrun_o <= 1'b0;
         if (clk1n_en_i) begin
            de_q        <= de_i;
            ra_q        <= ra_i;
            gfx_q       <= gfx_i;
            vram_addr_o <= ma_i[10:0];
            rom_req_o   <= 1'b0;
            restart     <= busy;
            if (busy) begin
               // Abort: requests drop on this edge so the stale ack is never
               // taken; the new character's fetch is launched from IDLE next cycle.
               underrun_o <= 1'b1;
               vram_req_o <= 1'b0;
               state      <= IDLE;
            end else if (de_i && (ra_i[4:3] == 2'b00)) begin
               vram_req_o <= 1'b1;
               state      <= VRAM;
            end else begin
               vram_req_o  <= 1'b0;
               pending     <= '0;
               pending_inv <= 1'b0;
               state       <= READY;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (restart) begin
                     restart <= 1'b0;
                     if (de_q && (ra_q[4:3] == 2'b00)) begin
                        vram_req_o <= 1'b1;
                        state      <= VRAM;
                     end else begin
                        pending     <= '0;
                        pending_inv <= 1'b0;
                        state       <= READY;
                     end
                  end
               end
               VRAM: begin
                  if (vram_ack_i) begin
                     vram_req_o  <= 1'b0;
                     rom_req_o   <= 1'b1;
                     pending_inv <= vram_data_i[7];
                     rom_addr_o  <= {gfx_q, vram_data_i[6:0], ra_q[2:0]};
                     state       <= ROM;
                  end
               end
               ROM: begin
                  if (rom_ack_i) begin
                     rom_req_o <= 1'b0;
                     pending   <= rom_data_i;
                     state     <= READY;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Pixel shifter and sync delay: load on the character strobe, shift otherwise.
   always_ff @(posedge sys_clock_i) begin
      if (reset_i) begin
         shreg    <= '0;
         inv_q    <= 1'b0;
         h_pipe   <= 1'b0;
         v_pipe   <= 1'b0;
         h_sync_o <= 1'b0;
         v_sync_o <= 1'b0;
      end else if (clk1n_en_i) begin
         shreg    <= (state == READY) ? pending : '0;
         inv_q    <= (state == READY) && pending_inv;
         h_pipe   <= h_sync_i;
         v_pipe   <= v_sync_i;
         h_sync_o <= h_pipe;
         v_sync_o <= v_pipe;
      end else if (pixel_en_i) begin
         shreg <= {shreg[6:0], 1'b0};
      end
   end

   assign video_o = shreg[7] ^ inv_q;

endmodule

// File: tb/tb_video_pixel_gen.sv
// tb_video_pixel_gen: directed character table with a pixel/sync scoreboard.
module tb_video_pixel_gen;

   logic        sys_clock_i = 1'b0;
   logic        reset_i, clk1n_en_i, pixel_en_i, de_i, h_sync_i, v_sync_i, gfx_i;
   logic [13:0] ma_i;
   logic [4:0]  ra_i;
   logic [10:0] vram_addr_o, rom_addr_o;
   logic        vram_req_o, vram_ack_i, rom_req_o, rom_ack_i;
   logic [7:0]  vram_data_i, rom_data_i;
   logic        video_o, h_sync_o, v_sync_o, underrun_o;

   video_pixel_gen dut (
      .sys_clock_i(sys_clock_i), .reset_i(reset_i), .clk1n_en_i(clk1n_en_i),
      .pixel_en_i(pixel_en_i), .de_i(de_i), .ma_i(ma_i), .ra_i(ra_i),
      .h_sync_i(h_sync_i), .v_sync_i(v_sync_i), .gfx_i(gfx_i),
      .vram_addr_o(vram_addr_o), .vram_req_o(vram_req_o), .vram_ack_i(vram_ack_i),
      .vram_data_i(vram_data_i), .rom_addr_o(rom_addr_o), .rom_req_o(rom_req_o),
      .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .video_o(video_o),
      .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .underrun_o(underrun_o)
   );

   always #5 sys_clock_i = ~sys_clock_i;

   typedef struct {
      logic        de;
      logic [13:0] ma;
      logic [4:0]  ra;
      logic        gfx;
      logic        hs;
      logic        vs;
      logic        late;
      int unsigned vwait;
      logic [7:0]  vdata;
      logic [7:0]  rdata;
      logic        fetch;
      logic [10:0] vaddr;
      logic [10:0] raddr;
      logic [7:0]  pix;
      logic        urun;
   } entry_t;

   localparam int NE = 7;
   entry_t     tbl[NE];
   int         checks = 0;
   int         failures = 0;
   logic       mon_en = 1'b0;
   logic       pix_q[$];
   logic [2:0] ctl_q[$];
   logic       strobe_d = 1'b0;
   logic       pix_d = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_video"}, video_o, 0);
      check({tag, "_hsync"}, h_sync_o, 0);
      check({tag, "_vsync"}, v_sync_o, 0);
      check({tag, "_underrun"}, underrun_o, 0);
      check({tag, "_vram_req"}, vram_req_o, 0);
      check({tag, "_rom_req"}, rom_req_o, 0);
      check({tag, "_vram_addr"}, vram_addr_o, 0);
      check({tag, "_rom_addr"}, rom_addr_o, 0);
   endtask

   // One memory-responder cycle used during the reset scenario.
   task automatic serve(input logic [7:0] vd, input logic [7:0] rd);
      vram_ack_i = 1'b0;
      rom_ack_i  = 1'b0;
      if (vram_req_o) begin
         vram_ack_i  = 1'b1;
         vram_data_i = vd;
      end else if (rom_req_o) begin
         rom_ack_i  = 1'b1;
         rom_data_i = rd;
      end
   endtask

   always @(posedge sys_clock_i) begin
      strobe_d <= clk1n_en_i;
      pix_d    <= pixel_en_i;
   end

   // Monitor: every shifted pixel and every post-strobe sync/underrun sample.
   always @(negedge sys_clock_i) begin
      if (mon_en) begin
         if (pix_d) begin
            if (pix_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL video_extra: got pixel %0b with no expectation queued", video_o);
            end else begin
               logic e;
               e = pix_q.pop_front();
               check("video", video_o, e);
            end
         end
         if (strobe_d) begin
            if (ctl_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL ctl_extra: strobe with no expectation queued");
            end else begin
               logic [2:0] c;
               c = ctl_q.pop_front();
               check("underrun", underrun_o, c[2]);
               check("h_sync", h_sync_o, c[1]);
               check("v_sync", v_sync_o, c[0]);
            end
         end else begin
            check("underrun_idle", underrun_o, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      entry_t e;
      logic   found;
      logic   req_seen;
      int unsigned vcnt;

      tbl[0] = '{1, 14'h0005, 5'd2, 0, 0, 0, 0, 0, 8'h41, 8'hA5, 1, 11'h005, 11'h20A, 8'hA5, 0};
      tbl[1] = '{1, 14'h3C12, 5'd7, 1, 1, 0, 0, 2, 8'hC1, 8'hA5, 1, 11'h412, 11'h60F, 8'h5A, 0};
      tbl[2] = '{0, 14'h0123, 5'd0, 0, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 11'h123, 11'h000, 8'h00, 0};
      tbl[3] = '{1, 14'h0124, 5'd9, 0, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 11'h124, 11'h000, 8'h00, 0};
      tbl[4] = '{1, 14'h0055, 5'd1, 0, 0, 0, 1, 0, 8'h80, 8'hFF, 1, 11'h055, 11'h000, 8'h00, 1};
      tbl[5] = '{1, 14'h22AA, 5'd4, 0, 1, 1, 0, 1, 8'h3C, 8'h81, 1, 11'h2AA, 11'h1E4, 8'h81, 0};
      tbl[6] = '{1, 14'h00FF, 5'd3, 1, 0, 0, 0, 0, 8'h80, 8'h00, 1, 11'h0FF, 11'h403, 8'hFF, 0};

      reset_i = 1'b1; clk1n_en_i = 1'b0; pixel_en_i = 1'b0; de_i = 1'b0;
      ma_i = '0; ra_i = '0; gfx_i = 1'b0; h_sync_i = 1'b0; v_sync_i = 1'b0;
      vram_ack_i = 1'b0; rom_ack_i = 1'b0; vram_data_i = '0; rom_data_i = '0;

      repeat (3) @(negedge sys_clock_i);
      check_all_zero("reset");
      reset_i = 1'b0;

      // Reset scenario: build up visible state, then reset while in ROM.
      @(negedge sys_clock_i);
      clk1n_en_i = 1'b1; de_i = 1'b1; ma_i = 14'h0011; ra_i = 5'd0;
      h_sync_i = 1'b1; v_sync_i = 1'b1;
      @(negedge sys_clock_i);
      clk1n_en_i = 1'b0;
      repeat (6) begin
         serve(8'h01, 8'hFF);
         @(negedge sys_clock_i);
      end
      vram_ack_i = 1'b0; rom_ack_i = 1'b0;
      clk1n_en_i = 1'b1; ma_i = 14'h0022;
      @(negedge sys_clock_i);
      clk1n_en_i = 1'b0;
      check("pre_reset_video", video_o, 1);
      check("pre_reset_hsync", h_sync_o, 1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (rom_req_o) found = 1'b1;
         else begin
            serve(8'h02, 8'hFF);
            @(negedge sys_clock_i);
         end
      end
      vram_ack_i = 1'b0; rom_ack_i = 1'b0;
      if (!found) begin
         checks++;
         failures++;
         $display("FAIL rom_req_timeout: rom_req_o never rose within 10 cycles");
      end
      reset_i = 1'b1;
      @(negedge sys_clock_i);
      check_all_zero("midfetch_reset");
      de_i = 1'b0; h_sync_i = 1'b0; v_sync_i = 1'b0; ma_i = '0;
      repeat (2) @(negedge sys_clock_i);
      mon_en = 1'b1;
      reset_i = 1'b0;

      // Character table; flush strobe at k == NE displays the last entry.
      for (int k = 0; k <= NE; k++) begin
         @(negedge sys_clock_i);
         vram_ack_i = 1'b0; rom_ack_i = 1'b0;
         clk1n_en_i = 1'b1; pixel_en_i = 1'b1;
         if (k < NE) begin
            de_i = tbl[k].de; ma_i = tbl[k].ma; ra_i = tbl[k].ra; gfx_i = tbl[k].gfx;
            h_sync_i = tbl[k].hs; v_sync_i = tbl[k].vs;
         end else begin
            de_i = 1'b0; h_sync_i = 1'b0; v_sync_i = 1'b0;
         end
         if (k > 0 && tbl[k-1].late) begin
            // Ack coinciding with the strobe is too late and must be dropped.
            vram_ack_i = 1'b1; vram_data_i = 8'hFF;
         end
         if (k == 0) begin
            ctl_q.push_back(3'b000);
            for (int b = 0; b < 8; b++) pix_q.push_back(1'b0);
         end else begin
            e = tbl[k-1];
            ctl_q.push_back({e.urun, e.hs, e.vs});
            for (int b = 7; b >= 0; b--) pix_q.push_back(e.pix[b]);
         end
         @(negedge sys_clock_i);
         clk1n_en_i = 1'b0;
         vcnt = 0;
         req_seen = 1'b0;
         for (int j = 1; j <= 7; j++) begin
            vram_ack_i = 1'b0; rom_ack_i = 1'b0;
            if (k < NE) begin
               if (vram_req_o || rom_req_o) req_seen = 1'b1;
               if (j == 1 && k > 0 && tbl[k-1].late) begin
                  check("abort_vram_req", vram_req_o, 0);
                  vram_ack_i = 1'b1; vram_data_i = 8'hFF;
               end else if (vram_req_o && !tbl[k].late) begin
                  if (vcnt == tbl[k].vwait) begin
                     check("vram_addr", vram_addr_o, tbl[k].vaddr);
                     vram_ack_i = 1'b1; vram_data_i = tbl[k].vdata;
                  end else begin
                     vcnt++;
                  end
               end else if (rom_req_o) begin
                  check("rom_addr", rom_addr_o, tbl[k].raddr);
                  rom_ack_i = 1'b1; rom_data_i = tbl[k].rdata;
               end
            end
            if (j < 7) @(negedge sys_clock_i);
         end
         if (k < NE && !tbl[k].fetch) check("blank_no_req", req_seen, 0);
      end
      @(negedge sys_clock_i);
      pixel_en_i = 1'b0;
      vram_ack_i = 1'b0; rom_ack_i = 1'b0;
      repeat (3) @(negedge sys_clock_i);
      check("pix_queue_empty", pix_q.size(), 0);
      check("ctl_queue_empty", ctl_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
